max_sub_replay_block: RTL and testbench
=======================================

Name: max_sub_replay_block

Overview:
- Softmax datapath stage that sits on the consumer side of max_tree_block.
- Captures the same N-sample input frame that feeds the max tree.
- Waits for the max tree's done pulse, latches the maximum, then replays the frame as x_i - max, one sample per cycle.
- Its output feeds the exponent stage.

Parameters:
- data_size, 32, width of each signed two's-complement sample.
- number_of_data, 10, samples per frame (N ≥ 2).
- addr_size, $clog2(number_of_data), buffer index width; derived localparam, not overridable.

Ports:
- clock_i  in  1  rising-edge clock.
- reset_i  in  1  synchronous reset, active-high.
- start_i  in  1  frame-capture enable; one sample accepted per cycle while high.
- data_i  in  data_size  input sample; same stream that drives max_tree_block.
- data_max_i  in  data_size  frame maximum from max_tree_block.
- max_done_i  in  1  one-cycle pulse; data_max_i is valid in that cycle.
- data_o  out  data_size  registered result x_i - max.
- valid_o  out  1  data_o valid this cycle.
- last_o  out  1  high with the final replayed sample.
- sub_done_o  out  1  one-cycle pulse after the frame completes.
- busy_o  out  1  high in any state other than IDLE.

Behaviour:
- Reset, sampled on a clock edge with reset_i=1: state=IDLE, wr_idx=rd_idx=0, max_pending=0, data_o=0, valid_o=0, last_o=0, sub_done_o=0, busy_o=0. Buffer contents are not cleared. Reset mid-frame aborts the frame; no output pulse follows.
- IDLE: start_i=1 at an edge writes data_i to buf[0], sets wr_idx=1, goes to CAPTURE.
- CAPTURE: each edge with start_i=1 writes buf[wr_idx] and increments wr_idx. start_i=0 holds wr_idx (pause, no sample). When the N-th sample is written, go to WAIT_MAX.
- Max latch: max_done_i=1 in CAPTURE or WAIT_MAX latches data_max_i into max_reg and sets max_pending. This includes the edge that writes the N-th sample. max_done_i in IDLE, REPLAY or DONE is ignored.
- WAIT_MAX: if max_pending=1 (or max_done_i=1 this edge), set rd_idx=0 and go to REPLAY.
- REPLAY: each edge registers data_o=buf[rd_idx]-max_reg with valid_o=1, then increments rd_idx.
  - last_o=1 together with the sample at rd_idx=N-1; the state then goes to DONE.
  - valid_o is continuous for exactly N cycles; there is no back-pressure.
  - Latency: valid_o rises 1 cycle after max_done_i is sampled in WAIT_MAX.
- DONE: sub_done_o=1 for one cycle; valid_o=last_o=0; clear max_pending; go to IDLE.
  - The next frame may start on the edge after DONE.
  - start_i=1 during WAIT_MAX, REPLAY or DONE is ignored; no sample is written.
- Arithmetic: full-width signed subtraction truncated to data_size, i.e. wrap-around when the true difference is below the signed minimum.
- data_o holds its last value when valid_o=0.

Optional Feature:
- Macro: MAX_SUB_SATURATE_EN.
- Defined: if the signed difference underflows, data_o = the most-negative value (1 followed by zeros).
  - Overflow is impossible when max is correct. Any positive result, i.e. an inconsistent max, clamps to 0.
- Undefined: plain wrap-around subtraction; no extra logic.

Decomposition:
- Package softmax_pkg:
  - default data_size and number_of_data constants.
  - state encoding constants (IDLE, CAPTURE, WAIT_MAX, REPLAY, DONE).
  - signed-min constant helper.
- Sub-module sample_buffer_block: number_of_data x data_size register file with synchronous write port (we, waddr, wdata) and asynchronous read port (raddr, rdata).
- FSM, counters and subtractor stay in the top module.

Test Plan:
- Basic frame, N=10: stream 3,-7,9,0,-2,5,1,-10,4,8; pulse max_done_i with data_max_i=9 two cycles after the last sample -> valid_o for 10 consecutive cycles with data_o = -6,-16,0,-9,-11,-4,-8,-19,-5,-1; last_o with -1; sub_done_o on the next cycle.
- Early max: max_done_i (max=9) on the same edge as the 10th write -> REPLAY entered on the next edge with no lost max; same 10 outputs.
- Capture pause: start_i low for 3 cycles after the 4th sample -> wr_idx holds; the final output sequence equals the un-paused case.
- Ignored inputs: max_done_i in IDLE, and start_i toggling during REPLAY -> no state change, no extra valid_o, buffer unchanged.
- Reset mid-REPLAY: reset_i=1 after the 4th output -> next cycle valid_o=0, busy_o=0, no sub_done_o; a fresh frame afterwards replays correctly.
- Underflow, data_size=8: sample -128 with max=127 -> data_o=1 (wrap) without MAX_SUB_SATURATE_EN; -128 with MAX_SUB_SATURATE_EN.

Source files
------------

// File: rtl/softmax_pkg.sv
// Shared constants and state encoding for the softmax datapath stages.
package softmax_pkg;

  localparam int unsigned default_data_size      = 32;
  localparam int unsigned default_number_of_data = 10;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    WAIT_MAX,
    REPLAY,
    DONE
  } sub_state_t;

  // Most-negative two's-complement value of a width-bit word, right-aligned in 64 bits.
  function automatic logic [63:0] signed_min(input int unsigned width);
    return 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/sample_buffer_block.sv
// Frame register file: one synchronous write port, one asynchronous read port.
module sample_buffer_block
  import softmax_pkg::*;
#(
  parameter int unsigned data_size      = default_data_size,
  parameter int unsigned number_of_data = default_number_of_data,
  parameter int unsigned addr_size      = $clog2(number_of_data)
) (
  input  logic                 clock_i,
  input  logic                 we,
  input  logic [addr_size-1:0] waddr,
  input  logic [data_size-1:0] wdata,
  input  logic [addr_size-1:0] raddr,
  output logic [data_size-1:0] rdata
);

  logic [data_size-1:0] mem [number_of_data];

  // NOTE: storage is deliberately not reset; every entry is written before it is replayed.
  always_ff @(posedge clock_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/max_sub_replay_block.sv
// Captures a frame, waits for the max tree result, then replays x_i - max one per cycle.
// Optional MAX_SUB_SATURATE_EN clamps underflow to the signed minimum instead of wrapping.
module max_sub_replay_block
  import softmax_pkg::*;
#(
  parameter int unsigned data_size      = default_data_size,
  parameter int unsigned number_of_data = default_number_of_data
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 start_i,
  input  logic [data_size-1:0] data_i,
  input  logic [data_size-1:0] data_max_i,
  input  logic                 max_done_i,
  output logic [data_size-1:0] data_o,
  output logic                 valid_o,
  output logic                 last_o,
  output logic                 sub_done_o,
  output logic                 busy_o
);

  localparam int unsigned          addr_size = $clog2(number_of_data);
  localparam logic [addr_size-1:0] last_idx  = addr_size'(number_of_data - 1);

  sub_state_t           state, state_next;
  logic [addr_size-1:0] wr_idx, rd_idx;
  logic                 max_pending;
  logic [data_size-1:0] max_reg;
  logic                 buf_we, max_latch;
  logic [data_size-1:0] buf_rdata, diff_out;

  sample_buffer_block #(
    .data_size      (data_size),
    .number_of_data (number_of_data),
    .addr_size      (addr_size)
  ) u_buffer (
    .clock_i (clock_i),
    .we      (buf_we),
    .waddr   (wr_idx),
    .wdata   (data_i),
    .raddr   (rd_idx),
    .rdata   (buf_rdata)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path leaves a latch behind.
    state_next = state;
    buf_we     = 1'b0;
    max_latch  = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_i) begin
          buf_we     = 1'b1;
          state_next = CAPTURE;
        end
      end
      CAPTURE: begin
        buf_we    = start_i;
        max_latch = max_done_i;
        if (start_i && (wr_idx == last_idx)) state_next = WAIT_MAX;
      end
      WAIT_MAX: begin
        max_latch = max_done_i;
        if (max_pending || max_done_i) state_next = REPLAY;
      end
      REPLAY:  if (rd_idx == last_idx) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // wr_idx wraps to 0 after the final write, so IDLE always writes buf[0].
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state       <= IDLE;
      wr_idx      <= '0;
      rd_idx      <= '0;
      max_pending <= 1'b0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      last_o      <= 1'b0;
      sub_done_o  <= 1'b0;
    end else begin
      state      <= state_next;
      valid_o    <= 1'b0;
      last_o     <= 1'b0;
      sub_done_o <= 1'b0;
      if (buf_we) wr_idx <= (wr_idx == last_idx) ? '0 : wr_idx + 1'b1;
      if (max_latch) max_pending <= 1'b1;
      if (state == WAIT_MAX) rd_idx <= '0;
      if (state == REPLAY) begin
        data_o  <= diff_out;
        valid_o <= 1'b1;
        last_o  <= (rd_idx == last_idx);
        rd_idx  <= rd_idx + 1'b1;
      end
      if (state == DONE) begin
        sub_done_o  <= 1'b1;
        max_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (max_latch) max_reg <= data_max_i;
  end

`ifdef MAX_SUB_SATURATE_EN
  localparam logic [data_size-1:0] sat_min = data_size'(signed_min(data_size));
  logic signed [data_size:0] diff;

  assign diff = $signed({buf_rdata[data_size-1], buf_rdata})
              - $signed({max_reg[data_size-1], max_reg});

  // A positive difference only arises from an inconsistent max and is clamped to zero.
  always_comb begin
    if (diff[data_size] && !diff[data_size-1])       diff_out = sat_min;
    else if (!diff[data_size] && (diff != '0))       diff_out = '0;
    else                                             diff_out = diff[data_size-1:0];
  end
`else
  assign diff_out = buf_rdata - max_reg;
`endif

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_max_sub_replay_block.sv
// Self-checking bench: directed and random frames against a queue-free arithmetic model.
module tb_max_sub_replay_block;

  localparam int DW = 8;
  localparam int N  = 10;

  logic          clock_i = 1'b0;
  logic          reset_i, start_i, max_done_i;
  logic [DW-1:0] data_i, data_max_i, data_o;
  logic          valid_o, last_o, sub_done_o, busy_o;

  int total = 0;
  int bad   = 0;
  int frame [N];

  always #5 clock_i = ~clock_i;

  max_sub_replay_block #(
    .data_size      (DW),
    .number_of_data (N)
  ) dut (
    .clock_i    (clock_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .data_i     (data_i),
    .data_max_i (data_max_i),
    .max_done_i (max_done_i),
    .data_o     (data_o),
    .valid_o    (valid_o),
    .last_o     (last_o),
    .sub_done_o (sub_done_o),
    .busy_o     (busy_o)
  );

  // Expected x - max computed on plain integers, then wrapped or clamped to DW bits.
  function automatic logic [DW-1:0] ref_sub(input int x, input int m);
    int d;
    d = x - m;
`ifdef MAX_SUB_SATURATE_EN
    if (d < -(1 << (DW - 1))) return {1'b1, {(DW-1){1'b0}}};
    if (d > 0) return '0;
`endif
    return DW'(d);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock_i);
    #1;
  endtask

  // max_delay > 0: pulse that many cycles after the last sample;
  // max_delay <= 0: pulse on the edge writing sample N-1+max_delay.
  task automatic run_frame(input int maxv, input int max_delay, input int pause_at,
                           input int pause_len, input bit toggle, input int abort_after);
    int lat;
    int exp_lat;
    logic [DW-1:0] last_val;
    for (int i = 0; i < N; i++) begin
      start_i = 1'b1;
      data_i  = DW'(frame[i]);
      if (max_delay <= 0 && i == N - 1 + max_delay) begin
        max_done_i = 1'b1;
        data_max_i = DW'(maxv);
      end
      tick();
      start_i    = 1'b0;
      max_done_i = 1'b0;
      data_i     = DW'($urandom);
      data_max_i = DW'($urandom);
      if (i == pause_at) repeat (pause_len) tick();
    end
    if (max_delay > 0) begin
      repeat (max_delay - 1) tick();
      check("busy_wait_max", busy_o, 1'b1);
      max_done_i = 1'b1;
      data_max_i = DW'(maxv);
      tick();
      max_done_i = 1'b0;
      data_max_i = DW'($urandom);
    end
    exp_lat = (max_delay <= 0) ? 2 : 1;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!valid_o && lat < 8);
    check("latency", lat, exp_lat);
    for (int k = 0; k < N; k++) begin
      if (k > 0) tick();
      last_val = ref_sub(frame[k], maxv);
      check($sformatf("valid[%0d]", k), valid_o, 1'b1);
      check($sformatf("data[%0d]", k), data_o, last_val);
      check($sformatf("last[%0d]", k), last_o, (k == N - 1));
      if (abort_after == k + 1) begin
        start_i = 1'b0;
        reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("abort_valid", valid_o, 1'b0);
        check("abort_busy", busy_o, 1'b0);
        check("abort_done", sub_done_o, 1'b0);
        repeat (3) begin
          tick();
          check("abort_quiet", {valid_o, sub_done_o, busy_o}, 3'b000);
        end
        return;
      end
      if (toggle) begin
        start_i    = 1'($urandom_range(0, 1));
        data_i     = DW'($urandom);
        max_done_i = 1'($urandom_range(0, 1));
        data_max_i = DW'($urandom);
      end
    end
    start_i    = 1'b0;
    max_done_i = 1'b0;
    tick();
    check("done_valid", valid_o, 1'b0);
    check("done_last", last_o, 1'b0);
    check("done_pulse", sub_done_o, 1'b1);
    check("done_hold", data_o, last_val);
    tick();
    check("idle_pulse", sub_done_o, 1'b0);
    check("idle_busy", busy_o, 1'b0);
    check("idle_valid", valid_o, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic signed [DW-1:0] s;
    int mx;
    reset_i    = 1'b1;
    start_i    = 1'b0;
    max_done_i = 1'b0;
    data_i     = '0;
    data_max_i = '0;
    repeat (2) tick();
    check("rst_data", data_o, '0);
    check("rst_ctrl", {valid_o, last_o, sub_done_o, busy_o}, 4'b0000);
    reset_i = 1'b0;
    tick();
    check("rst_idle_busy", busy_o, 1'b0);

    // A max pulse while idle must not be remembered.
    max_done_i = 1'b1;
    data_max_i = 8'h55;
    tick();
    max_done_i = 1'b0;
    check("idle_max_busy", busy_o, 1'b0);
    check("idle_max_valid", valid_o, 1'b0);

    frame = '{3, -7, 9, 0, -2, 5, 1, -10, 4, 8};
    run_frame(9, 2, -1, 0, 1'b0, 0);
    run_frame(9, 0, -1, 0, 1'b0, 0);
    run_frame(9, 2, 3, 3, 1'b0, 0);
    run_frame(9, 1, -1, 0, 1'b1, 0);
    run_frame(9, 1, -1, 0, 1'b0, 4);

    frame = '{-128, 127, 0, -1, 5, -100, 64, -128, 1, 2};
    run_frame(127, 1, -1, 0, 1'b0, 0);

    for (int f = 0; f < 8; f++) begin
      mx = -128;
      for (int i = 0; i < N; i++) begin
        s = DW'($urandom);
        frame[i] = s;
        if (frame[i] > mx) mx = frame[i];
      end
      if (f % 2 == 1) begin
        s  = DW'($urandom);
        mx = s;
      end
      run_frame(mx, int'($urandom_range(0, 5)) - 2, int'($urandom_range(0, N - 2)),
                int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
